// File: rtl/tmds_pkg.sv
// Shared TMDS constants, types and helpers for the bit-clock serializer.
package tmds_pkg;

  localparam int unsigned TMDS_W = 10;

  typedef logic [TMDS_W-1:0] tmds_word_t;

  // DVI control-period symbols; C00 doubles as the idle symbol.
  localparam tmds_word_t TMDS_C00 = 10'b1101010100;
  localparam tmds_word_t TMDS_C01 = 10'b0010101011;
  localparam tmds_word_t TMDS_C10 = 10'b0101010100;
  localparam tmds_word_t TMDS_C11 = 10'b1010101011;

  localparam tmds_word_t TMDS_CLK_PATTERN = 10'b0000011111;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/tmds_serializer_gearbox_fifo.sv
// Single-clock power-of-two FIFO with occupancy output and a registered ready flag.
module sync_fifo
  import tmds_pkg::*;
#(
  parameter int unsigned WIDTH = 30,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  output logic                     wr_ready,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [LW-1:0]    count;
  logic [LW-1:0]    count_nxt;
  logic             do_wr;
  logic             do_rd;

  assign do_wr   = wr_en && wr_ready;
  assign do_rd   = rd_en && (count != '0);
  assign empty   = (count == '0);
  assign level   = count;
  assign rd_data = mem[rd_ptr];

  always_comb begin
    count_nxt = count;
    if (do_wr && !do_rd)
      count_nxt = count + 1'b1;
    else if (!do_wr && do_rd)
      count_nxt = count - 1'b1;
  end

  // Ready is held low through reset and tracks the post-edge occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      wr_ready <= 1'b0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      count    <= count_nxt;
      wr_ready <= (count_nxt != LW'(DEPTH));
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/tmds_serializer_gearbox.sv
// Bit-clock TMDS serializer: buffered parallel symbols shifted out on every lane plus a clock lane.
module tmds_serializer_gearbox
  import tmds_pkg::*;
#(
  parameter int unsigned           NUM_CHANNELS  = 3,
  parameter int unsigned           WORD_WIDTH    = TMDS_W,
  parameter int unsigned           FIFO_DEPTH    = 4,
  parameter bit                    LSB_FIRST     = 1'b1,
  parameter bit                    CLOCK_LANE    = 1'b1,
  parameter logic [WORD_WIDTH-1:0] CLOCK_PATTERN = WORD_WIDTH'(TMDS_CLK_PATTERN),
  parameter logic [WORD_WIDTH-1:0] IDLE_WORD     = WORD_WIDTH'(TMDS_C00)
) (
  input  logic                                    clk_serial,
  input  logic                                    reset_n,
  input  logic [NUM_CHANNELS-1:0][WORD_WIDTH-1:0] in_word,
  input  logic                                    in_valid,
  output logic                                    in_ready,
  input  logic                                    enable,
  input  logic                                    clear_status,
  output logic [NUM_CHANNELS-1:0]                 tmds,
  output logic                                    tmds_clock,
  output logic                                    word_start,
  output logic                                    underrun,
  output logic [7:0]                              underrun_count,
  output logic [$clog2(FIFO_DEPTH):0]             fifo_level
);

  localparam int PW = $clog2(WORD_WIDTH);
  localparam int DW = NUM_CHANNELS * WORD_WIDTH;
  localparam logic [PW-1:0] LAST_PHASE = PW'(WORD_WIDTH - 1);

  typedef logic [NUM_CHANNELS-1:0][WORD_WIDTH-1:0] lane_arr_t;

  function automatic logic [WORD_WIDTH-1:0] shift1(input logic [WORD_WIDTH-1:0] v);
    return LSB_FIRST ? (v >> 1) : (v << 1);
  endfunction

  function automatic logic out_bit(input logic [WORD_WIDTH-1:0] v);
    return LSB_FIRST ? v[0] : v[WORD_WIDTH-1];
  endfunction

  logic [PW-1:0]         phase;
  logic                  load;
  logic                  empty;
  logic                  pop;
  logic                  starve;
  logic [DW-1:0]         head;
  lane_arr_t             head_lanes;
  lane_arr_t             shreg;
  logic [WORD_WIDTH-1:0] clk_sh;

  assign load       = (phase == LAST_PHASE);
  assign pop        = load && enable && !empty;
  assign starve     = load && enable && empty;
  assign head_lanes = head;

  sync_fifo #(
    .WIDTH (DW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk_serial),
    .rst_n    (reset_n),
    .wr_en    (in_valid),
    .wr_data  (in_word),
    .wr_ready (in_ready),
    .rd_en    (pop),
    .rd_data  (head),
    .empty    (empty),
    .level    (fifo_level)
  );

  // Phase counter and shifters: load on the last phase, shift on every other edge.
  always_ff @(posedge clk_serial or negedge reset_n) begin
    if (!reset_n) begin
      phase      <= '0;
      shreg      <= '0;
      clk_sh     <= '0;
      word_start <= 1'b0;
    end else begin
      phase      <= load ? '0 : phase + 1'b1;
      word_start <= load;
      if (load) begin
        for (int i = 0; i < NUM_CHANNELS; i++)
          shreg[i] <= pop ? head_lanes[i] : IDLE_WORD;
        clk_sh <= CLOCK_PATTERN;
      end else begin
        for (int i = 0; i < NUM_CHANNELS; i++)
          shreg[i] <= shift1(shreg[i]);
        clk_sh <= shift1(clk_sh);
      end
    end
  end

  always_comb begin
    tmds = '0;
    for (int i = 0; i < NUM_CHANNELS; i++)
      tmds[i] = out_bit(shreg[i]);
  end

  assign tmds_clock = CLOCK_LANE ? out_bit(clk_sh) : 1'b0;

  // A fresh underrun wins over a same-cycle clear, restarting the count at one.
  always_ff @(posedge clk_serial or negedge reset_n) begin
    if (!reset_n) begin
      underrun       <= 1'b0;
      underrun_count <= '0;
    end else if (starve) begin
      underrun       <= 1'b1;
      underrun_count <= clear_status ? 8'd1 : sat_inc8(underrun_count);
    end else if (clear_status) begin
      underrun       <= 1'b0;
      underrun_count <= '0;
    end
  end

endmodule

// File: tb/tb_tmds_serializer_gearbox.sv
// Directed bench: an LSB-first DUT with clock lane and an MSB-first DUT without, driven in parallel.
module tb_tmds_serializer_gearbox;

  localparam int N = 3;
  localparam int W = 10;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 reset_n = 1'b0;
  logic [N-1:0][W-1:0]  in_word = '0;
  logic                 in_valid = 1'b0;
  logic                 enable = 1'b0;
  logic                 clear_status = 1'b0;

  logic                 in_ready_l, in_ready_m;
  logic [N-1:0]         tmds_l, tmds_m;
  logic                 tmds_clock_l, tmds_clock_m;
  logic                 word_start_l, word_start_m;
  logic                 underrun_l, underrun_m;
  logic [7:0]           count_l, count_m;
  logic [2:0]           level_l, level_m;

  tmds_serializer_gearbox dut_l (
    .clk_serial     (clk),
    .reset_n        (reset_n),
    .in_word        (in_word),
    .in_valid       (in_valid),
    .in_ready       (in_ready_l),
    .enable         (enable),
    .clear_status   (clear_status),
    .tmds           (tmds_l),
    .tmds_clock     (tmds_clock_l),
    .word_start     (word_start_l),
    .underrun       (underrun_l),
    .underrun_count (count_l),
    .fifo_level     (level_l)
  );

  tmds_serializer_gearbox #(
    .LSB_FIRST  (1'b0),
    .CLOCK_LANE (1'b0)
  ) dut_m (
    .clk_serial     (clk),
    .reset_n        (reset_n),
    .in_word        (in_word),
    .in_valid       (in_valid),
    .in_ready       (in_ready_m),
    .enable         (enable),
    .clear_status   (clear_status),
    .tmds           (tmds_m),
    .tmds_clock     (tmds_clock_m),
    .word_start     (word_start_m),
    .underrun       (underrun_m),
    .underrun_count (count_m),
    .fifo_level     (level_m)
  );

  typedef struct {
    logic [N-1:0][W-1:0] word;
    logic [N-1:0][W-1:0] exp_l;  // bit k = value on the lane k cycles after word_start
    logic [N-1:0][W-1:0] exp_m;
  } vec_t;

  vec_t tab [4];

  localparam logic [N-1:0][W-1:0] IDLE_L = {10'h354, 10'h354, 10'h354};
  localparam logic [N-1:0][W-1:0] IDLE_M = {10'h0AB, 10'h0AB, 10'h0AB};
  localparam logic [W-1:0]        CLK_L  = 10'h01F;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    cyc++;
  endtask

  task automatic run_to(input int t);
    while (cyc < t) step();
  endtask

  task automatic do_reset(input logic en);
    reset_n = 1'b0; in_valid = 1'b0; clear_status = 1'b0; in_word = '0; enable = en;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    cyc = 0;
  endtask

  // Expects to be called at cyc = 10*m; samples one full word period.
  task automatic capture(input string tag, input logic [N-1:0][W-1:0] el,
                         input logic [N-1:0][W-1:0] em, input logic [W-1:0] ec);
    logic [N-1:0][W-1:0] sl, sm;
    logic [W-1:0] sc, scm, swl, swm;
    for (int k = 0; k < W; k++) begin
      for (int i = 0; i < N; i++) begin
        sl[i][k] = tmds_l[i];
        sm[i][k] = tmds_m[i];
      end
      sc[k]  = tmds_clock_l;
      scm[k] = tmds_clock_m;
      swl[k] = word_start_l;
      swm[k] = word_start_m;
      step();
    end
    for (int i = 0; i < N; i++) begin
      check($sformatf("%s lsb lane%0d", tag, i), 32'(sl[i]), 32'(el[i]));
      check($sformatf("%s msb lane%0d", tag, i), 32'(sm[i]), 32'(em[i]));
    end
    check({tag, " clock lane"}, 32'(sc), 32'(ec));
    check({tag, " clock tied"}, 32'(scm), 32'h0);
    check({tag, " word_start lsb"}, 32'(swl), 32'h001);
    check({tag, " word_start msb"}, 32'(swm), 32'h001);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic acc;
    tab[0] = '{word: {10'h3FF, 10'h000, 10'h155}, exp_l: {10'h3FF, 10'h000, 10'h155}, exp_m: {10'h3FF, 10'h000, 10'h2AA}};
    tab[1] = '{word: {10'h001, 10'h200, 10'h0F0}, exp_l: {10'h001, 10'h200, 10'h0F0}, exp_m: {10'h200, 10'h001, 10'h03C}};
    tab[2] = '{word: {10'h3E0, 10'h1B7, 10'h2C5}, exp_l: {10'h3E0, 10'h1B7, 10'h2C5}, exp_m: {10'h01F, 10'h3B6, 10'h28D}};
    tab[3] = '{word: {10'h155, 10'h3FF, 10'h000}, exp_l: {10'h155, 10'h3FF, 10'h000}, exp_m: {10'h2AA, 10'h3FF, 10'h000}};

    // First word after reset, with an underrun on the very first load.
    reset_n = 1'b0; enable = 1'b1;
    repeat (3) @(negedge clk);
    check("reset tmds", 32'(tmds_l), 32'h0);
    check("reset tmds_clock", 32'(tmds_clock_l), 32'h0);
    check("reset word_start", 32'(word_start_l), 32'h0);
    check("reset underrun", 32'({underrun_l, count_l}), 32'h0);
    check("reset fifo_level", 32'(level_l), 32'h0);
    check("reset in_ready", 32'(in_ready_l), 32'h0);
    reset_n = 1'b1; cyc = 0;
    step();
    check("in_ready after release", 32'(in_ready_l), 32'h1);
    acc = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      acc = acc | (|tmds_l) | (|tmds_m) | tmds_clock_l | word_start_l | underrun_l;
      if (k == 9) begin
        in_valid = 1'b1;
        in_word  = tab[0].word;
      end
      step();
    end
    in_valid = 1'b0;
    check("first period quiet", 32'(acc), 32'h0);
    check("first load underrun", 32'({underrun_l, count_l}), 32'h101);
    check("write on load edge queued", 32'(level_l), 32'h1);
    capture("idle p1", IDLE_L, IDLE_M, CLK_L);
    capture("word0", tab[0].exp_l, tab[0].exp_m, CLK_L);
    check("underrun count p3", 32'(count_l), 32'h2);
    capture("idle p3", IDLE_L, IDLE_M, CLK_L);
    check("underrun count p4", 32'(count_l), 32'h3);
    clear_status = 1'b1;
    step();
    clear_status = 1'b0;
    check("clear status", 32'({underrun_l, count_l}), 32'h0);

    // Burst into a held-off FIFO, then drain in order.
    do_reset(1'b0);
    step();
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_word  = tab[i].word;
      step();
    end
    in_word = {10'h3FF, 10'h3FF, 10'h3FF};
    check("full in_ready", 32'(in_ready_l), 32'h0);
    check("full level", 32'(level_l), 32'h4);
    run_to(8);
    in_valid = 1'b0;
    run_to(10);
    check("disabled load no pop", 32'(level_l), 32'h4);
    check("disabled load no underrun", 32'(underrun_l), 32'h0);
    check("still full in_ready", 32'(in_ready_l), 32'h0);
    enable = 1'b1;
    capture("disabled idle", IDLE_L, IDLE_M, CLK_L);
    check("in_ready after first pop", 32'(in_ready_l), 32'h1);
    check("level after first pop", 32'(level_l), 32'h3);
    for (int i = 0; i < 4; i++)
      capture($sformatf("burst%0d", i), tab[i].exp_l, tab[i].exp_m, CLK_L);
    check("drained level", 32'(level_l), 32'h0);
    check("drained underrun", 32'(underrun_l), 32'h1);

    // Reset mid-word discards queued data.
    do_reset(1'b0);
    step();
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1;
      in_word  = tab[i].word;
      step();
    end
    in_valid = 1'b0;
    run_to(10);
    enable = 1'b1;
    run_to(23);
    check("pre-reset lane2", 32'(tmds_l[2]), 32'h1);
    check("pre-reset level", 32'(level_l), 32'h1);
    #2 reset_n = 1'b0;
    #1;
    check("async reset tmds", 32'({tmds_l, tmds_m}), 32'h0);
    check("async reset clock/start", 32'({tmds_clock_l, word_start_l}), 32'h0);
    check("async reset level", 32'(level_l), 32'h0);
    check("async reset in_ready", 32'(in_ready_l), 32'h0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1; cyc = 0;
    run_to(10);
    check("post-reset level", 32'(level_l), 32'h0);
    check("post-reset underrun", 32'(underrun_l), 32'h1);
    capture("post-reset idle", IDLE_L, IDLE_M, CLK_L);

    // Saturating counter and clear colliding with a new underrun.
    do_reset(1'b1);
    run_to(2545);
    check("count 254", 32'(count_l), 32'd254);
    run_to(2555);
    check("count 255", 32'(count_l), 32'd255);
    run_to(3005);
    check("count saturated", 32'({underrun_l, count_l}), 32'h1FF);
    run_to(3009);
    clear_status = 1'b1;
    step();
    clear_status = 1'b0;
    check("clear with underrun", 32'({underrun_l, count_l}), 32'h101);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
